// File: rtl/cpm_cq_credit_bridge.sv
// cpm_cq_credit_bridge
// Receive-side bridge from the CPM credit-based completer-request port to a
// valid/ready completer-request stream. Beats land in a FIFO sized to the
// credit pool; one credit is returned upstream for every beat drained.
// Protocol violations (beat while full, beat while down, credit accounting
// out of range) raise sticky error flags that only user_reset clears.
module cpm_cq_credit_bridge #(
  parameter int DEPTH          = 32,
  parameter int DATA_WIDTH     = 512,
  parameter int IN_USER_WIDTH  = 229,
  parameter int OUT_USER_WIDTH = 183
) (
  input  logic                      user_clk,
  input  logic                      user_reset,
  input  logic                      link_up,
  input  logic [DATA_WIDTH-1:0]     s_cq_tdata,
  input  logic [IN_USER_WIDTH-1:0]  s_cq_tuser,
  input  logic                      s_cq_tlast,
  input  logic [DATA_WIDTH/32-1:0]  s_cq_tkeep,
  input  logic                      s_cq_tvalid,
  output logic                      s_cq_credit,
  output logic [DATA_WIDTH-1:0]     m_cq_tdata,
  output logic [OUT_USER_WIDTH-1:0] m_cq_tuser,
  output logic                      m_cq_tlast,
  output logic [DATA_WIDTH/32-1:0]  m_cq_tkeep,
  output logic                      m_cq_tvalid,
  input  logic [21:0]               m_cq_tready,
  output logic                      err_overflow,
  output logic                      err_credit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = DATA_WIDTH / 32;

  localparam logic [0:0] ST_DOWN = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  // Parameter sanity: the pointer scheme needs a power-of-two depth.
  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpm_cq_credit_bridge: DEPTH must be a power of two in 4..256");
  end
  if (OUT_USER_WIDTH > IN_USER_WIDTH) begin : g_bad_user
    $error("cpm_cq_credit_bridge: OUT_USER_WIDTH must not exceed IN_USER_WIDTH");
  end
  if (DATA_WIDTH % 32 != 0) begin : g_bad_data
    $error("cpm_cq_credit_bridge: DATA_WIDTH must be a multiple of 32");
  end

  // Upper sideband bits are not forwarded downstream.
  if (IN_USER_WIDTH > OUT_USER_WIDTH) begin : g_user_trim
    logic unused_user_hi;
    assign unused_user_hi = ^s_cq_tuser[IN_USER_WIDTH-1:OUT_USER_WIDTH];
  end

  // Only ready bit 0 carries meaning.
  logic unused_tready_hi;
  assign unused_tready_hi = ^m_cq_tready[21:1];

  logic [0:0]    state;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] cred_pend;
  logic [CW-1:0] cred_out;
  logic          credit_p1;

  logic [DATA_WIDTH-1:0]     mem_data [DEPTH];
  logic [OUT_USER_WIDTH-1:0] mem_user [DEPTH];
  logic                      mem_last [DEPTH];
  logic [KW-1:0]             mem_keep [DEPTH];

  logic          run;
  logic          stay_run;
  logic          fifo_empty;
  logic          fifo_full;
  logic          head_vld;
  logic          pop;
  logic          push;
  logic          drop_full;
  logic          issue;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] pop_inc;
  logic [CW-1:0] issue_dec;
  logic [CW-1:0] credit_inc;
  logic [CW-1:0] push_dec;

  assign run      = (state == ST_RUN);
  assign stay_run = run & link_up;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign head_vld  = run & ~fifo_empty;
  assign pop       = head_vld & m_cq_tready[0];
  // A pop on a full FIFO frees the head slot in the same edge, so a
  // simultaneous push is accepted.
  assign push      = s_cq_tvalid & run & (~fifo_full | pop);
  assign drop_full = s_cq_tvalid & run & fifo_full & ~pop;
  assign issue     = (cred_pend != '0);

  assign pop_inc    = {{(CW-1){1'b0}}, pop};
  assign issue_dec  = {{(CW-1){1'b0}}, issue};
  assign credit_inc = {{(CW-1){1'b0}}, credit_p1};
  assign push_dec   = {{(CW-1){1'b0}}, push};

  // Link state, FIFO pointers and credit accounting; anything other than
  // staying in RUN holds the block flushed with the full pool pending.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state     <= ST_DOWN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cred_pend <= CRED_FULL;
      cred_out  <= '0;
      credit_p1 <= 1'b0;
    end else if (stay_run) begin
      state <= ST_RUN;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cred_pend <= cred_pend + pop_inc - issue_dec;
      // A credit underflow wraps above DEPTH and is caught by err_credit.
      cred_out  <= cred_out + credit_inc - push_dec;
      credit_p1 <= issue;
    end else begin
      state     <= link_up ? ST_RUN : ST_DOWN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cred_pend <= CRED_FULL;
      cred_out  <= '0;
      credit_p1 <= 1'b0;
    end
  end

  // Sticky protocol error flags.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      if (drop_full) err_overflow <= 1'b1;
      if ((~run & s_cq_tvalid) | (run & (cred_out > CRED_FULL))) err_credit <= 1'b1;
    end
  end

  // Beat storage; data path carries no reset.
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem_data[wr_idx] <= s_cq_tdata;
      mem_user[wr_idx] <= s_cq_tuser[OUT_USER_WIDTH-1:0];
      mem_last[wr_idx] <= s_cq_tlast;
      mem_keep[wr_idx] <= s_cq_tkeep;
    end
  end

  // Head of FIFO drives the stream; zeroed when no beat is presented.
  always_comb begin
    m_cq_tvalid = head_vld;
    m_cq_tdata  = '0;
    m_cq_tuser  = '0;
    m_cq_tlast  = 1'b0;
    m_cq_tkeep  = '0;
    if (head_vld) begin
      m_cq_tdata = mem_data[rd_idx];
      m_cq_tuser = mem_user[rd_idx];
      m_cq_tlast = mem_last[rd_idx];
      m_cq_tkeep = mem_keep[rd_idx];
    end
  end

  assign s_cq_credit = credit_p1;

endmodule
